// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR (NUM_BITS = 3..32) with seed load and sequence-complete flag.
// Optional macro LFSR_LOCKUP_RECOVERY_EN forces the all-ones lockup state back to zero.
module lfsr_core #(
  parameter int NUM_BITS = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);

  logic [NUM_BITS-1:0] lfsr_r;
  logic                feedback_s;

  // XAPP052 maximal-length taps; XNOR keeps all-zeros legal and makes all-ones the lockup state
  generate
    case (NUM_BITS)
      3:  begin : g_taps assign feedback_s = ~(lfsr_r[2] ^ lfsr_r[1]); end
      4:  begin : g_taps assign feedback_s = ~(lfsr_r[3] ^ lfsr_r[2]); end
      5:  begin : g_taps assign feedback_s = ~(lfsr_r[4] ^ lfsr_r[2]); end
      6:  begin : g_taps assign feedback_s = ~(lfsr_r[5] ^ lfsr_r[4]); end
      7:  begin : g_taps assign feedback_s = ~(lfsr_r[6] ^ lfsr_r[5]); end
      8:  begin : g_taps assign feedback_s = ~(lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]); end
      9:  begin : g_taps assign feedback_s = ~(lfsr_r[8] ^ lfsr_r[4]); end
      10: begin : g_taps assign feedback_s = ~(lfsr_r[9] ^ lfsr_r[6]); end
      11: begin : g_taps assign feedback_s = ~(lfsr_r[10] ^ lfsr_r[8]); end
      12: begin : g_taps assign feedback_s = ~(lfsr_r[11] ^ lfsr_r[5] ^ lfsr_r[3] ^ lfsr_r[0]); end
      13: begin : g_taps assign feedback_s = ~(lfsr_r[12] ^ lfsr_r[3] ^ lfsr_r[2] ^ lfsr_r[0]); end
      14: begin : g_taps assign feedback_s = ~(lfsr_r[13] ^ lfsr_r[4] ^ lfsr_r[2] ^ lfsr_r[0]); end
      15: begin : g_taps assign feedback_s = ~(lfsr_r[14] ^ lfsr_r[13]); end
      16: begin : g_taps assign feedback_s = ~(lfsr_r[15] ^ lfsr_r[14] ^ lfsr_r[12] ^ lfsr_r[3]); end
      17: begin : g_taps assign feedback_s = ~(lfsr_r[16] ^ lfsr_r[13]); end
      18: begin : g_taps assign feedback_s = ~(lfsr_r[17] ^ lfsr_r[10]); end
      19: begin : g_taps assign feedback_s = ~(lfsr_r[18] ^ lfsr_r[5] ^ lfsr_r[1] ^ lfsr_r[0]); end
      20: begin : g_taps assign feedback_s = ~(lfsr_r[19] ^ lfsr_r[16]); end
      21: begin : g_taps assign feedback_s = ~(lfsr_r[20] ^ lfsr_r[18]); end
      22: begin : g_taps assign feedback_s = ~(lfsr_r[21] ^ lfsr_r[20]); end
      23: begin : g_taps assign feedback_s = ~(lfsr_r[22] ^ lfsr_r[17]); end
      24: begin : g_taps assign feedback_s = ~(lfsr_r[23] ^ lfsr_r[22] ^ lfsr_r[21] ^ lfsr_r[16]); end
      25: begin : g_taps assign feedback_s = ~(lfsr_r[24] ^ lfsr_r[21]); end
      26: begin : g_taps assign feedback_s = ~(lfsr_r[25] ^ lfsr_r[5] ^ lfsr_r[1] ^ lfsr_r[0]); end
      27: begin : g_taps assign feedback_s = ~(lfsr_r[26] ^ lfsr_r[4] ^ lfsr_r[1] ^ lfsr_r[0]); end
      28: begin : g_taps assign feedback_s = ~(lfsr_r[27] ^ lfsr_r[24]); end
      29: begin : g_taps assign feedback_s = ~(lfsr_r[28] ^ lfsr_r[26]); end
      30: begin : g_taps assign feedback_s = ~(lfsr_r[29] ^ lfsr_r[5] ^ lfsr_r[3] ^ lfsr_r[0]); end
      31: begin : g_taps assign feedback_s = ~(lfsr_r[30] ^ lfsr_r[27]); end
      32: begin : g_taps assign feedback_s = ~(lfsr_r[31] ^ lfsr_r[21] ^ lfsr_r[1] ^ lfsr_r[0]); end
      default: begin : g_taps_illegal
        $error("lfsr_core: NUM_BITS=%0d outside legal range 3..32", NUM_BITS);
        assign feedback_s = 1'b0;
      end
    endcase
  endgenerate

  // State register: reset beats seed load, seed load beats lockup recovery and shift
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lfsr_r <= {NUM_BITS{1'b0}};
    end else if (i_Seed_DV) begin
      lfsr_r <= i_Seed_Data;
`ifdef LFSR_LOCKUP_RECOVERY_EN
    end else if (lfsr_r == {NUM_BITS{1'b1}}) begin
      lfsr_r <= {NUM_BITS{1'b0}};
`endif
    end else if (i_Enable) begin
      lfsr_r <= {lfsr_r[NUM_BITS-2:0], feedback_s};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign o_LFSR_Data = lfsr_r;
  // Compared against the live seed input, so the flag tracks seed changes without a cycle of lag
  assign o_LFSR_Done = (lfsr_r == i_Seed_Data);

endmodule

// File: tb/tb_lfsr_core.sv
// Directed, table-driven bench for lfsr_core at NUM_BITS=4 and NUM_BITS=8.
module tb_lfsr_core;

  logic       clk = 1'b0;
  logic       rst4, en4, dv4;
  logic [3:0] seed4, q4;
  logic       done4;
  logic       rst8, en8, dv8;
  logic [7:0] seed8, q8;
  logic       done8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_core #(.NUM_BITS(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst4), .i_Enable(en4), .i_Seed_DV(dv4),
    .i_Seed_Data(seed4), .o_LFSR_Data(q4), .o_LFSR_Done(done4));

  lfsr_core #(.NUM_BITS(8)) dut8 (
    .i_Clk(clk), .i_Rst(rst8), .i_Enable(en8), .i_Seed_DV(dv8),
    .i_Seed_Data(seed8), .o_LFSR_Data(q8), .o_LFSR_Done(done8));

  typedef struct {
    logic       rst;
    logic       en;
    logic       dv;
    logic [3:0] seed;
    logic [3:0] exp_q;
    logic       exp_done;
  } vec_t;

  vec_t tbl[32];
  int   n_tbl = 0;

  task automatic add(input logic rst, input logic en, input logic dv, input logic [3:0] seed,
                     input logic [3:0] exp_q, input logic exp_done);
    tbl[n_tbl] = '{rst, en, dv, seed, exp_q, exp_done};
    n_tbl++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive 4-bit inputs just after an edge, then sample 1 ns after the next edge
  task automatic step4(input logic rst, input logic en, input logic dv, input logic [3:0] seed);
    rst4 = rst; en4 = en; dv4 = dv; seed4 = seed;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vals[300];
  logic       dones[300];
  logic       seen[256];
  int         distinct;
  int         per_err;

  initial begin
    rst4 = 1'b1; en4 = 1'b0; dv4 = 1'b0; seed4 = 4'h0;
    rst8 = 1'b1; en8 = 1'b0; dv8 = 1'b0; seed8 = 8'h0;
    @(posedge clk);
    #1;

    // reset beats load; then the full 15-state cycle from zero
    add(1'b1, 1'b0, 1'b1, 4'h3, 4'h0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h7, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hD, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hB, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h6, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hC, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h9, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hA, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h7, 1'b0);
    // hold, load while disabled, load overriding shift, hold at seed
    add(1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h9, 4'h2, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'h5, 4'h5, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h5, 4'hA, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b1);

    for (int i = 0; i < n_tbl; i++) begin
      step4(tbl[i].rst, tbl[i].en, tbl[i].dv, tbl[i].seed);
      check($sformatf("tbl[%0d].q", i), 32'(q4), 32'(tbl[i].exp_q));
      check($sformatf("tbl[%0d].done", i), 32'(done4), 32'(tbl[i].exp_done));
    end

    // hold at 7 for 10 disabled cycles with seed 0
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step4(1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step4(1'b0, 1'b0, 1'b0, 4'h0);
      check("hold7.q", 32'(q4), 32'h7);
      check("hold7.done", 32'(done4), 32'h0);
    end

    // asynchronous reset between edges while q=B, then resume from zero
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) step4(1'b0, 1'b1, 1'b0, 4'h0);
    check("pre_async.q", 32'(q4), 32'hB);
    #2;
    rst4 = 1'b1;
    #1;
    check("async_rst.q", 32'(q4), 32'h0);
    check("async_rst.done", 32'(done4), 32'h1);
    step4(1'b0, 1'b1, 1'b0, 4'h0);
    check("resume1.q", 32'(q4), 32'h1);
    step4(1'b0, 1'b1, 1'b0, 4'h0);
    check("resume3.q", 32'(q4), 32'h3);
    step4(1'b0, 1'b1, 1'b0, 4'h0);
    check("resume7.q", 32'(q4), 32'h7);

    // all-ones lockup seed
    step4(1'b0, 1'b0, 1'b1, 4'hF);
    check("lock_load.q", 32'(q4), 32'hF);
    check("lock_load.done", 32'(done4), 32'h1);
`ifdef LFSR_LOCKUP_RECOVERY_EN
    step4(1'b0, 1'b0, 1'b0, 4'hF);
    check("lock_recover.q", 32'(q4), 32'h0);
    step4(1'b0, 1'b1, 1'b0, 4'hF);
    check("lock_after.q", 32'(q4), 32'h1);
`else
    for (int i = 0; i < 20; i++) begin
      step4(1'b0, 1'b1, 1'b0, 4'hF);
      check("lock_stay.q", 32'(q4), 32'hF);
    end
`endif

    // 8-bit: 300 enabled cycles from reset
    rst8 = 1'b0; en8 = 1'b1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      vals[i] = q8;
      dones[i] = done8;
    end
    en8 = 1'b0;
    check("w8.v0", 32'(vals[0]), 32'h01);
    check("w8.v1", 32'(vals[1]), 32'h03);
    check("w8.v2", 32'(vals[2]), 32'h07);
    check("w8.v3", 32'(vals[3]), 32'h0F);
    check("w8.v4", 32'(vals[4]), 32'h1E);
    check("w8.wrap_q", 32'(vals[254]), 32'h00);
    check("w8.wrap_done", 32'(dones[254]), 32'h1);
    check("w8.mid_done", 32'(dones[100]), 32'h0);
    distinct = 0;
    per_err = 0;
    for (int i = 0; i < 255; i++) begin
      if (!seen[vals[i]]) distinct++;
      seen[vals[i]] = 1'b1;
    end
    for (int i = 255; i < 300; i++) begin
      if (vals[i] !== vals[i-255]) per_err++;
    end
    check("w8.distinct", 32'(distinct), 32'd255);
    check("w8.ff_seen", 32'(seen[255]), 32'h0);
    check("w8.period_errs", 32'(per_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_core.md
Name: lfsr_core

Overview:
- Parameterizable Fibonacci linear-feedback shift register producing a maximal-length (2^NUM_BITS − 1 state) pseudo-random sequence.
- Uses XNOR feedback, so the all-zeros state is legal and is the reset state.
- Provides seed loading and a one-cycle "sequence complete" flag.
- Used as a pattern/noise source for display and test logic, e.g. MAX7219 framebuffer fill and stimulus generation.

Parameters:
- NUM_BITS, 8, register width; legal range 3..32. Any other value is a elaboration-time error ($error).

Ports:
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Rst  input  1  reset, asynchronous, active-high.
- i_Enable  input  1  advance the LFSR one step per cycle while high.
- i_Seed_DV  input  1  load i_Seed_Data into the register this cycle.
- i_Seed_Data  input  NUM_BITS  seed value; also the compare value for o_LFSR_Done.
- o_LFSR_Data  output  NUM_BITS  current register contents.
- o_LFSR_Done  output  1  high while o_LFSR_Data == i_Seed_Data.

Behaviour:
- Register q[NUM_BITS-1:0]; o_LFSR_Data = q directly, with no extra pipeline stage.
- Reset: i_Rst high clears q to 0 immediately, independent of clock. o_LFSR_Done after reset = (i_Seed_Data == 0).
- Per rising edge, when not in reset, with this priority:
  1. i_Seed_DV=1: q <= i_Seed_Data. The load takes effect regardless of i_Enable.
  2. else if i_Enable=1: q <= {q[NUM_BITS-2:0], fb}.
  3. else: hold.
- Feedback fb = XNOR of tap bits. Taps are 1-based (tap t means q[t-1]; tap NUM_BITS is the MSB), per XAPP052:
  - 3:3,2  4:4,3  5:5,3  6:6,5  7:7,6  8:8,6,5,4  9:9,5  10:10,7  11:11,9  12:12,6,4,1
  - 13:13,4,3,1  14:14,5,3,1  15:15,14  16:16,15,13,4  17:17,14  18:18,11  19:19,6,2,1
  - 20:20,17  21:21,19  22:22,21  23:23,18  24:24,23,22,17  25:25,22  26:26,6,2,1
  - 27:27,5,2,1  28:28,25  29:29,27  30:30,6,4,1  31:31,28  32:32,22,2,1
  - Select taps with a generate/case on NUM_BITS.
- Period: exactly 2^NUM_BITS − 1 steps from any non-lockup state.
- Lockup state: all-ones. Loading an all-ones seed makes the register stay all-ones, unless the optional feature below is enabled.
- o_LFSR_Done:
  - Combinational compare of q against the live i_Seed_Data.
  - With a constant seed and i_Enable held high, it is high for one cycle every 2^NUM_BITS − 1 cycles.
  - Stays high while the register holds at the seed value (enable low).
- Simultaneous events: reset overrides load; load overrides shift.
- Reset mid-sequence: q returns to 0 immediately; the sequence restarts from 0 on the first enabled edge after release.
- No X-propagation: all bits are defined after reset.

Optional Feature:
- Macro: LFSR_LOCKUP_RECOVERY_EN.
- When defined, and the register equals all-ones with i_Seed_DV=0, the next edge forces q <= 0 regardless of i_Enable. This recovers from an illegal seed within one cycle.
- When undefined, all-ones is a fixed point of the shift: the register remains all-ones until a new seed or reset.

Test Plan:
- NUM_BITS=4, reset then i_Enable=1, seed ports 0 → o_LFSR_Data sequence 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0,…; o_LFSR_Done high on each 0 (every 15 cycles).
- NUM_BITS=8, enable high for 300 cycles from reset → 255 distinct values, never FF, repeats with period 255.
- NUM_BITS=4, mid-sequence i_Seed_DV=1 with i_Seed_Data=9 while i_Enable=0 → next cycle q=9 and o_LFSR_Done=1; the following enabled step gives 2.
- Assert i_Rst asynchronously between clock edges while q=B → q=0 before the next edge; after release the sequence resumes 1,3,7.
- NUM_BITS=4, load seed F → with LFSR_LOCKUP_RECOVERY_EN, next enabled or disabled edge gives 0; without it, q stays F for 20 enabled cycles.
- i_Enable=0 for 10 cycles at q=7 → q holds 7; o_LFSR_Done=0 for seed 0.
